// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack port between the memory stage and the data bus.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [63:0] rdata;
  logic        ack;
  modport master(output req, we, addr, wdata, be, input rdata, ack);
  modport slave(input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage with req/ack data port and bus timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] result_i,
  input  logic [4:0]  reg_write_addr_i,
  input  logic        reg_write_enable_i,
  input  logic        mem_valid_i,
  input  logic        mem_rw_i,
  input  logic [63:0] store_data_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        stall_o,
  mem_stage_if.master dmem,
  output logic [63:0] result_o,
  output logic [4:0]  reg_write_addr_o,
  output logic        reg_write_enable_o,
  output logic        bus_err_o,
  output logic        exc_misaligned_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [4:0]           rd_l;
  logic                 we_l, ld_l, uns_l;
  logic [1:0]           size_l;
  logic [2:0]           off_l, off, off_a;
  logic [7:0]           mask;
  logic                 trap, issue, tmo, ack;
  logic [63:0]          sh, ld;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = off != off_a;
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    off     = result_i[2:0];
    off_a   = mem_size_i == 2'd3 ? 3'd0 : mem_size_i == 2'd2 ? (off & 3'd4) :
              mem_size_i == 2'd1 ? (off & 3'd6) : off;
    mask    = mem_size_i == 2'd3 ? 8'hFF : mem_size_i == 2'd2 ? 8'h0F :
              mem_size_i == 2'd1 ? 8'h03 : 8'h01;
    ack     = dmem.ack;
    tmo     = TIMEOUT_CYCLES != 0 && cnt == LAST && !ack;
    issue   = state == IDLE && mem_valid_i && !trap;
    state_n = state == IDLE ? (issue ? BUSY : IDLE) : (ack || tmo ? IDLE : BUSY);
    stall_o = rst_n && (state == IDLE ? issue : !ack && !tmo);
    sh      = dmem.rdata >> {off_l, 3'b000};
    ld      = size_l == 2'd3 ? sh :
              size_l == 2'd2 ? {{32{~uns_l & sh[31]}}, sh[31:0]} :
              size_l == 2'd1 ? {{48{~uns_l & sh[15]}}, sh[15:0]} :
                               {{56{~uns_l & sh[7]}}, sh[7:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      rd_l               <= '0;
      we_l               <= 1'b0;
      ld_l               <= 1'b0;
      uns_l              <= 1'b0;
      size_l             <= '0;
      off_l              <= '0;
      dmem.req           <= 1'b0;
      dmem.we            <= 1'b0;
      dmem.addr          <= '0;
      dmem.wdata         <= '0;
      dmem.be            <= '0;
      result_o           <= '0;
      reg_write_addr_o   <= '0;
      reg_write_enable_o <= 1'b0;
      bus_err_o          <= 1'b0;
      exc_misaligned_o   <= 1'b0;
    end else begin
      state            <= state_n;
      bus_err_o        <= 1'b0;
      exc_misaligned_o <= state == IDLE && mem_valid_i && trap;
      if (state == IDLE) begin
        if (!mem_valid_i || trap) begin
          result_o           <= result_i;
          reg_write_addr_o   <= reg_write_addr_i;
          reg_write_enable_o <= reg_write_enable_i && !mem_valid_i;
        end else begin
          dmem.req           <= 1'b1;
          dmem.we            <= mem_rw_i;
          dmem.addr          <= {result_i[63:3], 3'b000};
          dmem.be            <= mask << off_a;
          dmem.wdata         <= store_data_i << {off_a, 3'b000};
          cnt                <= '0;
          reg_write_enable_o <= 1'b0;
          rd_l               <= reg_write_addr_i;
          we_l               <= reg_write_enable_i;
          ld_l               <= !mem_rw_i;
          size_l             <= mem_size_i;
          uns_l              <= mem_unsigned_i;
          off_l              <= off_a;
        end
      end else if (ack) begin
        dmem.req           <= 1'b0;
        reg_write_enable_o <= ld_l && we_l;
        reg_write_addr_o   <= rd_l;
        if (ld_l) result_o <= ld;
      end else if (tmo) begin
        dmem.req           <= 1'b0;
        bus_err_o          <= 1'b1;
        reg_write_enable_o <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;
  localparam int TMO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] result_i = '0, store_data_i = '0;
  logic [4:0]  reg_write_addr_i = '0;
  logic        reg_write_enable_i = 1'b0, mem_valid_i = 1'b0, mem_rw_i = 1'b0, mem_unsigned_i = 1'b0;
  logic [1:0]  mem_size_i = '0;
  logic        stall_o, reg_write_enable_o, bus_err_o, exc_misaligned_o;
  logic [63:0] result_o;
  logic [4:0]  reg_write_addr_o;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .result_i(result_i), .reg_write_addr_i(reg_write_addr_i),
    .reg_write_enable_i(reg_write_enable_i), .mem_valid_i(mem_valid_i), .mem_rw_i(mem_rw_i),
    .store_data_i(store_data_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .stall_o(stall_o), .dmem(bus), .result_o(result_o), .reg_write_addr_o(reg_write_addr_o),
    .reg_write_enable_o(reg_write_enable_o), .bus_err_o(bus_err_o), .exc_misaligned_o(exc_misaligned_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] res; bit cres; logic [4:0] rd; bit crd; bit rwe; bit err; bit exc;} exp_t;
  typedef struct {logic [63:0] addr; logic [7:0] be; bit we; logic [63:0] wd;} bexp_t;
  exp_t  sb[$];
  bexp_t bq[$];
  int    n_vec = 0, n_bad = 0, ack_delay = 0;
  bit    drv_v = 1'b0, resp_en = 1'b1;
  logic [7:0]  rmem [logic [63:0]];
  logic [63:0] bmem [logic [63:0]];

  function automatic logic [7:0] init_byte(logic [63:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rb(logic [63:0] a);
    return rmem.exists(a) ? rmem[a] : init_byte(a);
  endfunction

  function automatic logic [63:0] bword(logic [63:0] wa);
    logic [63:0] w;
    if (bmem.exists(wa)) return bmem[wa];
    for (int i = 0; i < 8; i++) w[8*i +: 8] = init_byte(wa + 64'(i));
    return w;
  endfunction

  function automatic logic [63:0] ref_load(logic [63:0] ea, int n, bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rb(ea + 64'(i));
    if (!uns && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] bemask(logic [7:0] be);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Bus responder: acks after ack_delay BUSY cycles, never if the delay exceeds the timeout.
  initial begin
    int bc = 0;
    logic [63:0] w;
    bus.ack = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (bus.req) begin
          if (bc == ack_delay) begin
            bus.ack = 1'b1;
            bus.rdata = bword(bus.addr);
            if (bus.we) begin
              w = bword(bus.addr);
              for (int i = 0; i < 8; i++) if (bus.be[i]) w[8*i +: 8] = bus.wdata[8*i +: 8];
              bmem[bus.addr] = w;
            end
          end else bus.ack = 1'b0;
          bc++;
        end else begin
          bus.ack = 1'b0;
          bc = 0;
        end
      end
    end
  end

  // Monitor: compares retired results and each newly raised bus request.
  initial begin
    bit pend = 1'b0, pr = 1'b0;
    exp_t e;
    bexp_t b;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (e.cres) chk("result", result_o, e.res);
          if (e.crd) chk("rd", 64'(reg_write_addr_o), 64'(e.rd));
          chk("rwe", 64'(reg_write_enable_o), 64'(e.rwe));
          chk("bus_err", 64'(bus_err_o), 64'(e.err));
          chk("exc_misaligned", 64'(exc_misaligned_o), 64'(e.exc));
        end
      end
      if (bus.req && !pr) begin
        chk("busq_nonempty", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          b = bq.pop_front();
          chk("bus_addr", bus.addr, b.addr);
          chk("bus_be", 64'(bus.be), 64'(b.be));
          chk("bus_we", 64'(bus.we), 64'(b.we));
          if (b.we) chk("bus_wdata", bus.wdata & bemask(b.be), b.wd);
        end
      end
      pr = bus.req;
      pend = drv_v && !stall_o && rst_n;
    end
  end

  task automatic op(input bit mv, input bit rw, input logic [1:0] sz, input bit uns,
                    input logic [63:0] a, input logic [63:0] sd, input logic [4:0] rd,
                    input bit we, input int d);
    exp_t e;
    bexp_t b;
    int n = 1 << sz, exp_st = 0, st = 0, lane;
    logic [63:0] ea = a & ~64'(n - 1);
    bit trap = 1'b0;
    e = '{res: a, cres: 1'b1, rd: rd, crd: 1'b1, rwe: we, err: 1'b0, exc: 1'b0};
    if (mv) begin
`ifdef MEM_MISALIGN_TRAP_EN
      trap = ea != a;
`endif
      if (trap) begin
        e.rwe = 1'b0;
        e.exc = 1'b1;
      end else begin
        b = '{addr: ea & ~64'h7, be: 8'h00, we: rw, wd: '0};
        for (int i = 0; i < n; i++) begin
          lane = int'(ea[2:0]) + i;
          b.be[lane] = 1'b1;
          b.wd[8*lane +: 8] = sd[8*i +: 8];
        end
        bq.push_back(b);
        exp_st = d < TMO ? d + 1 : TMO;
        e.cres = !rw;
        e.crd = !rw;
        if (d >= TMO) begin
          e.cres = 1'b0;
          e.crd = 1'b0;
          e.rwe = 1'b0;
          e.err = 1'b1;
        end else if (rw) begin
          e.rwe = 1'b0;
          for (int i = 0; i < n; i++) rmem[ea + 64'(i)] = sd[8*i +: 8];
        end else e.res = ref_load(ea, n, uns);
      end
    end
    sb.push_back(e);
    result_i = a; store_data_i = sd; reg_write_addr_i = rd; reg_write_enable_i = we;
    mem_valid_i = mv; mem_rw_i = rw; mem_size_i = sz; mem_unsigned_i = uns;
    ack_delay = d; drv_v = 1'b1;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      st++;
      if (st > 40) break;
    end
    chk("stall_cycles", 64'(st), 64'(exp_st));
    @(posedge clk);
    #1;
    drv_v = 1'b0;
    mem_valid_i = 1'b0;
  endtask

  initial begin
    logic [63:0] w;
    mem_valid_i = 1'b1;
    result_i = 64'h1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 64'(bus.req), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_rwe", 64'(reg_write_enable_o), 64'd0);
    mem_valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, '0, 5'd5, 1'b1, 0);
    w = 64'h00000000_80000000;
    bmem[64'h1000] = w;
    for (int i = 0; i < 8; i++) rmem[64'h1000 + 64'(i)] = w[8*i +: 8];
    op(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, '0, 5'd3, 1'b1, 3);
    op(1'b1, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hABCD, 5'd4, 1'b1, 1);
    op(1'b1, 1'b0, 2'd1, 1'b0, 64'h2006, '0, 5'd6, 1'b1, 0);
    op(1'b1, 1'b0, 2'd2, 1'b1, 64'h1000, '0, 5'd8, 1'b1, 99);
    op(1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, '0, 5'd9, 1'b1, 2);
    op(1'b1, 1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0123_4567_89AB_CDEF, 5'd1, 1'b1, 0);
    op(1'b1, 1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, 5'd2, 1'b1, 3);
    op(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, '0, 5'd3, 1'b1, TMO - 1);
    for (int k = 0; k < 120; k++) begin
      int kind = int'($urandom_range(0, 9));
      op(kind < 3 ? 1'b0 : 1'b1, 1'($urandom), 2'($urandom), 1'($urandom),
         64'h1000 + 64'($urandom_range(0, 63)), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
         $urandom_range(0, 11) == 0 ? 99 : int'($urandom_range(0, TMO - 1)));
    end
    // Reset while a request is outstanding, then an ack that must be ignored.
    result_i = 64'h1008; mem_valid_i = 1'b1; mem_rw_i = 1'b0; mem_size_i = 2'd3; ack_delay = 99;
    bq.push_back('{addr: 64'h1008, be: 8'hFF, we: 1'b0, wd: '0});
    @(posedge clk);
    #1;
    mem_valid_i = 1'b0;
    chk("busy_req", 64'(bus.req), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus.req), 64'd0);
    chk("mid_rst_we", 64'(bus.we), 64'd0);
    chk("mid_rst_addr", bus.addr, 64'd0);
    chk("mid_rst_be", 64'(bus.be), 64'd0);
    chk("mid_rst_wdata", bus.wdata, 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    chk("mid_rst_rd", 64'(reg_write_addr_o), 64'd0);
    chk("mid_rst_rwe", 64'(reg_write_enable_o), 64'd0);
    chk("mid_rst_err", 64'(bus_err_o), 64'd0);
    chk("mid_rst_exc", 64'(exc_misaligned_o), 64'd0);
    chk("mid_rst_stall", 64'(stall_o), 64'd0);
    resp_en = 1'b0;
    bus.ack = 1'b1;
    bus.rdata = '1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    result_i = 64'h55; reg_write_addr_i = 5'd7; reg_write_enable_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_result", result_o, 64'h55);
    chk("post_rst_rwe", 64'(reg_write_enable_o), 64'd1);
    chk("post_rst_rd", 64'(reg_write_addr_o), 64'd7);
    chk("post_rst_req", 64'(bus.req), 64'd0);
    chk("post_rst_stall", 64'(stall_o), 64'd0);
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("busq_drained", 64'(bq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
